// File: rtl/tile_raster_z.sv
// tile_raster_z: scans a 2^TW_LOG2 x 2^TH_LOG2 tile in raster order. It steps three
// edge functions and a depth value incrementally, depth-tests each covered pixel
// against an internal depth buffer, and emits colour writes to the tile colour RAM.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start, mode_in     begin a pass (ignored while busy); 0 clear, 1 depth-tested
//                      draw, 2/3 unconditional draw
//   A*_in, B*_in       per-column / row-advance edge steps (B replaces A on last column)
//   w*_in              edge values at pixel (0,0)
//   z_in, dzdx_in,     depth at (0,0) and its column / row-advance steps, 8 frac bits
//   dzdy_in
//   color_in           draw colour (clear colour in mode 0)
//   pix_addr/wren/data colour RAM write port, address = {row, col}
//   busy, done         pass in progress / one-cycle completion pulse
//   pix_count          pixels written by the last pass
module tile_raster_z #(
  parameter int TW_LOG2 = 5,
  parameter int TH_LOG2 = 5,
  parameter int COLOR_W = 16,
  parameter int Z_W     = 24
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             start,
  input  logic [1:0]                       mode_in,
  input  logic signed [18:0]               A0_in,
  input  logic signed [18:0]               A1_in,
  input  logic signed [18:0]               A2_in,
  input  logic signed [23:0]               B0_in,
  input  logic signed [23:0]               B1_in,
  input  logic signed [23:0]               B2_in,
  input  logic signed [31:0]               w0_in,
  input  logic signed [31:0]               w1_in,
  input  logic signed [31:0]               w2_in,
  input  logic signed [Z_W+7:0]            z_in,
  input  logic signed [Z_W+7:0]            dzdx_in,
  input  logic signed [Z_W+7:0]            dzdy_in,
  input  logic [COLOR_W-1:0]               color_in,
  output logic [TW_LOG2+TH_LOG2-1:0]       pix_addr,
  output logic                             pix_wren,
  output logic [COLOR_W-1:0]               pix_data,
  output logic                             busy,
  output logic                             done,
  output logic [TW_LOG2+TH_LOG2:0]         pix_count
);

  localparam int AW = TW_LOG2 + TH_LOG2;
  localparam int N  = 1 << AW;
  localparam logic [Z_W-1:0] Z_FAR = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state, state_nxt;
  logic   load, s0_fire, last_col, last_pix;

  // Latched pass parameters and incremental accumulators
  logic [1:0]               mode_q;
  logic [COLOR_W-1:0]       color_q;
  logic signed [18:0]       a0_q, a1_q, a2_q;
  logic signed [23:0]       b0_q, b1_q, b2_q;
  logic signed [31:0]       w0, w1, w2;
  logic signed [Z_W+7:0]    z, dzdx_q, dzdy_q;
  logic [AW-1:0]            index;

  // Stage 0 results
  logic                     inside0;
  logic [Z_W-1:0]           zq0;

  // Stage 1 registers and depth buffer
  logic                     s1_valid, s1_inside;
  logic [Z_W-1:0]           s1_zq;
  logic [AW-1:0]            s1_addr;
  logic [Z_W-1:0]           zb_q;
  logic [Z_W-1:0]           zbuf [N];
  logic                     wr;
  logic [Z_W-1:0]           zb_wdata;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: a default assignment at the top of each combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    load    = (state == S_IDLE) && start;
    s0_fire = (state == S_RUN);
  end

  assign last_col = &index[TW_LOG2-1:0];
  assign last_pix = &index;

  function automatic logic signed [31:0] edge_step(input logic signed [18:0] a,
                                                   input logic signed [23:0] b,
                                                   input logic use_b);
    return use_b ? {{8{b[23]}}, b} : {{13{a[18]}}, a};
  endfunction

  // ---------------- Stage 0: coverage, depth quantise, step ----------------
  assign inside0 = ~w0[31] & ~w1[31] & ~w2[31];

  // The non-negative integer part of z always fits the Z_W field, so only the
  // negative side needs clamping.
  always_comb begin
    zq0 = z[Z_W+7:8];
    if (z[Z_W+7]) zq0 = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= '0;
      color_q <= '0;
      a0_q <= '0; a1_q <= '0; a2_q <= '0;
      b0_q <= '0; b1_q <= '0; b2_q <= '0;
      w0 <= '0; w1 <= '0; w2 <= '0;
      z <= '0; dzdx_q <= '0; dzdy_q <= '0;
      index <= '0;
    end else if (load) begin
      mode_q  <= mode_in;
      color_q <= color_in;
      a0_q <= A0_in; a1_q <= A1_in; a2_q <= A2_in;
      b0_q <= B0_in; b1_q <= B1_in; b2_q <= B2_in;
      w0 <= w0_in; w1 <= w1_in; w2 <= w2_in;
      z <= z_in; dzdx_q <= dzdx_in; dzdy_q <= dzdy_in;
      index <= '0;
    end else if (s0_fire) begin
      w0 <= w0 + edge_step(a0_q, b0_q, last_col);
      w1 <= w1 + edge_step(a1_q, b1_q, last_col);
      w2 <= w2 + edge_step(a2_q, b2_q, last_col);
      z  <= z + (last_col ? dzdy_q : dzdx_q);
      index <= index + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_inside <= 1'b0;
      s1_zq     <= '0;
      s1_addr   <= '0;
    end else begin
      s1_valid  <= s0_fire;
      s1_inside <= inside0;
      s1_zq     <= zq0;
      s1_addr   <= index;
    end
  end

  // ---------------- Stage 1: depth test and write ----------------
  // mode_q only changes on load, which cannot coincide with a stage-1 pixel.
  always_comb begin
    wr = 1'b0;
    case (mode_q)
      2'd0:    wr = s1_valid;
      2'd1:    wr = s1_valid && s1_inside && (s1_zq < zb_q);
      default: wr = s1_valid && s1_inside;
    endcase
  end

  assign zb_wdata = (mode_q == 2'd0) ? Z_FAR : s1_zq;

  // NOTE: the depth RAM has no reset; its contents are defined by a clear pass.
  // Each address is read and written once per pass, so the read at index never
  // collides with the write at s1_addr.
  always_ff @(posedge clk) begin
    if (wr) zbuf[s1_addr] <= zb_wdata;
    zb_q <= zbuf[index];
  end

  // The write port is driven straight from the stage-1 flops and the RAM read
  // register, so pixel k's write is visible in cycle k+2 after start.
  assign pix_wren = wr;
  assign pix_addr = s1_addr;
  assign pix_data = wr ? color_q : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DRAIN);
      if (load)    pix_count <= '0;
      else if (wr) pix_count <= pix_count + (AW+1)'(1);
    end
  end

endmodule

// File: doc/tile_raster_z.md
# tile_raster_z

Parametrised successor to the fixed 32x32 tile renderer. It scans a W x H tile and evaluates three edge functions incrementally. It interpolates depth, performs a depth test against an internal per-tile depth buffer, and emits colour writes to the external tile colour buffer. It sits between the triangle setup unit (which supplies edge and depth coefficients) and the tile colour RAM, and supports clear, depth-tested draw and unconditional draw modes.

## Interface
- TW_LOG2, default 5: log2 of tile width in pixels.
- TH_LOG2, default 5: log2 of tile height in pixels.
- COLOR_W, default 16: colour word width.
- Z_W, default 24: stored depth width (unsigned).
- clk, input, 1: clock.
- resetn, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a pass; sampled only while busy=0.
- mode_in, input, 2: 0 = clear, 1 = draw with depth test, 2 = draw without depth test, 3 = reserved (treated as 2).
- A0_in / A1_in / A2_in, input, 19 each (signed): per-column edge steps.
- B0_in / B1_in / B2_in, input, 24 each (signed): row-advance edge steps, applied in place of A on the last column.
- w0_in / w1_in / w2_in, input, 32 each (signed): edge values at pixel (0,0).
- z_in, input, Z_W+8 (signed): depth at (0,0), 8 fractional bits.
- dzdx_in, input, Z_W+8 (signed): per-column depth step.
- dzdy_in, input, Z_W+8 (signed): row-advance depth step, applied in place of dzdx on the last column.
- color_in, input, COLOR_W: draw colour, or clear colour in mode 0.
- pix_addr, output, TW_LOG2+TH_LOG2: colour RAM address, {row, col}.
- pix_wren, output, 1: colour RAM write enable.
- pix_data, output, COLOR_W: colour RAM write data.
- busy, output, 1: pass in progress.
- done, output, 1: one-cycle pulse when a pass completes.
- pix_count, output, TW_LOG2+TH_LOG2+1: pixels written in the last pass; held until the next start.

## Operation
- N = 2^(TW_LOG2+TH_LOG2) pixels per pass, scanned in raster order.
- Idle: busy=0. On start, latch all *_in values, set index=0, clear pix_count and enter RUN. A start while busy=1 is ignored.
- RUN, stage 0 (one pixel per cycle):
  - inside = w0, w1 and w2 are all non-negative (sign bit 0).
  - zq = z[Z_W+7:8], saturated to 0 when z is negative and to 2^Z_W-1 on positive overflow of the Z_W field.
  - Issue a depth-buffer read at index.
  - Advance each w by its A step sign-extended to 32 bits, or by its B step (sign-extended) when col == 2^TW_LOG2-1.
  - Advance z by dzdx, or by dzdy on the last column.
  - index increments.
- RUN, stage 1 (next cycle): depth-buffer read data zb is valid.
  - Mode 0: write color_in to the colour RAM and write 2^Z_W-1 to the depth buffer, for every pixel.
  - Mode 1: write colour and depth (zq) only when inside and zq < zb. Equal depth fails the test.
  - Mode 2: write colour and depth (zq) when inside; zb is ignored.
  - pix_count increments on each write.
- Depth buffer: internal 2^(TW_LOG2+TH_LOG2) x Z_W RAM with 1-cycle read latency.
  - Each address is touched once per pass, so there is no read-after-write hazard within a pass.
  - Contents are undefined after reset until a mode 0 pass runs.
- The last pixel is issued when index == N-1. Stage 1 drains next cycle, then the block returns to idle.
- Edge and depth arithmetic wraps in two's complement. Setup guarantees no overflow of the edge functions.

## Timing
- Reset: pix_addr=0, pix_wren=0, pix_data=0, busy=0, done=0, pix_count=0, state IDLE.
- Cycle 0: start sampled.
- Cycle 1: busy=1, pixel 0 in stage 0.
- Cycle k+2: write decision for pixel k appears on pix_wren, pix_addr and pix_data (registered).
- Cycle N+1: last possible write.
- Cycle N+2: done=1 and busy=0.
- A new start is accepted in cycle N+2, so back-to-back passes take a period of N+2 cycles.
- pix_data is 0 whenever pix_wren=0.
- resetn asserted mid-pass aborts the pass immediately; done is not pulsed.

## Test plan
- Mode 0 with color_in=16'hF800, default parameters -> 1024 writes at addr 0..1023 with data F800, done at cycle 1026, pix_count=1024.
- Mode 2, w0=w1=w2=0, all A=B=0 -> every pixel written. Then w0_in=-1 -> zero writes, pix_count=0, done still pulses.
- Half-plane: A0=-1, B0=31, w0=15, w1 and w2 large positive -> per row, columns 0..15 written and 16..31 not.
- Depth test: mode 0 clear, then mode 1 with z=100<<8 (pixels written), then mode 1 with z=200<<8 -> second draw writes nothing. Repeat with equal z -> nothing written.
- Overlapping starts: start asserted again at cycle 10 of a pass -> ignored, single done pulse. Reset at cycle 500 -> outputs return to reset values with no done.
- TW_LOG2=3, TH_LOG2=2, mode 0 -> 32 writes, done at cycle 34, row advance applied at columns 7, 15, 23 and 31.
